// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: op classes, supported
// data-processing commands, FSM state encoding and the address step.
package instr_encoder_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_WRITE = 2'd2,
    S_FULL  = 2'd3
  } state_e;

  localparam logic [31:0] ADDR_STEP = 32'd4;

  function automatic logic is_dp_cmd(input logic [3:0] cmd);
    return cmd inside {CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD, CMD_ORR};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Control, field-input and memory-write bundle of the instruction encoder.
// The master side drives fields and memory ready; the slave side is the encoder.
interface instr_encoder_if;

  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  max_words;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cond;
  logic [1:0]  in_op;
  logic [5:0]  in_funct;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [23:0] in_imm;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  logic        busy;
  logic        full;
  logic        err;
  logic [7:0]  word_count;
  logic [7:0]  err_count;

  modport master (
    output start, base_addr, max_words,
    output in_valid, in_cond, in_op, in_funct, in_rn, in_rd, in_imm,
    output mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  busy, full, err, word_count, err_count
  );

  modport slave (
    input  start, base_addr, max_words,
    input  in_valid, in_cond, in_op, in_funct, in_rn, in_rd, in_imm,
    input  mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output busy, full, err, word_count, err_count
  );

endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: builds the 32-bit instruction word and flags
// whether the field combination is a supported instruction.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  i_cond,
  input  logic [1:0]  i_op,
  input  logic [5:0]  i_funct,
  input  logic [3:0]  i_rn,
  input  logic [3:0]  i_rd,
  input  logic [23:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_word  = {i_cond, i_op, i_funct, i_rn, i_rd, i_imm[11:0]};
    o_legal = 1'b0;
    case (i_op)
      OP_DP:  o_legal = is_dp_cmd(i_funct[4:1]);
      OP_MEM: o_legal = 1'b1;
      OP_BR: begin
        // Branches carry only the link/cond bits of funct and a 24-bit offset.
        o_word  = {i_cond, OP_BR, i_funct[5:4], i_imm};
        o_legal = i_funct[5];
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded fields, packs them into words and
// writes them to consecutive instruction-memory addresses up to a word limit.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  instr_encoder_if.slave bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_in_ready;
  logic        r_busy;
  logic        r_full;
  logic        r_err;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [7:0]  r_word_count;
  logic [7:0]  r_err_count;
  logic [7:0]  r_max_words;

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_accept;
  logic        w_wr_done;
  logic [7:0]  w_count_inc;

  instr_pack u_pack (
    .i_cond  (bus.in_cond),
    .i_op    (bus.in_op),
    .i_funct (bus.in_funct),
    .i_rn    (bus.in_rn),
    .i_rd    (bus.in_rd),
    .i_imm   (bus.in_imm),
    .o_word  (w_word),
    .o_legal (w_legal)
  );

  assign w_accept    = (r_state == S_READY) && bus.in_valid;
  assign w_wr_done   = (r_state == S_WRITE) && bus.mem_ready;
  assign w_count_inc = r_word_count + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    if (bus.start) begin
      w_state_nxt = (bus.max_words == 8'd0) ? S_FULL : S_READY;
    end else begin
      case (r_state)
        S_READY: if (w_accept && w_legal) w_state_nxt = S_WRITE;
        S_WRITE: if (w_wr_done)
                   w_state_nxt = (w_count_inc == r_max_words) ? S_FULL : S_READY;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_word_count <= '0;
      r_err_count  <= '0;
      r_max_words  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_READY);
      r_busy     <= (w_state_nxt == S_READY) || (w_state_nxt == S_WRITE);
      r_full     <= (w_state_nxt == S_FULL);
      r_err      <= 1'b0;
      if (bus.start) begin
        // A restart abandons any write still waiting for mem_ready.
        r_mem_addr   <= bus.base_addr;
        r_max_words  <= bus.max_words;
        r_word_count <= '0;
        r_err_count  <= '0;
        r_mem_we     <= 1'b0;
      end else if (w_accept) begin
        if (w_legal) begin
          r_mem_wdata <= w_word;
          r_mem_we    <= 1'b1;
        end else begin
          r_err <= 1'b1;
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
      end else if (w_wr_done) begin
        r_mem_we     <= 1'b0;
        r_word_count <= w_count_inc;
        r_mem_addr   <= r_mem_addr + ADDR_STEP;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.busy       = r_busy;
  assign bus.full       = r_full;
  assign bus.err        = r_err;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.word_count = r_word_count;
  assign bus.err_count  = r_err_count;

endmodule
